f1_start_seq: RTL and testbench

- Parametrised F1 start-light sequencer with a built-in reaction timer. It is the next generation of the board-level start-light FSM and delay pair.
- Lights NUM_LIGHTS lamps one step at a time, holds all lamps on for a pseudo-random time, then blanks them. It measures driver reaction in ms and flags false starts.
- Sits between the clktick-generated 1 kHz strobe, the push-button inputs, and the LEDR / bin2bcd display path.

---
 rtl/f1_start_seq.sv | 175 +++++++++++++++++
 tb/tb_f1_start_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/f1_start_seq.sv
// rtl/f1_start_seq.sv - F1 start-light sequencer with random hold and reaction timer
// Optional blinking fault display after a false start: define F1_SEQ_BLINK_EN.
module f1_start_seq #(
  parameter int NUM_LIGHTS  = 10,
  parameter int STEP_MS     = 500,
  parameter int MIN_HOLD_MS = 250,
  parameter int HOLD_BITS   = 6,
  parameter int HOLD_SHIFT  = 2,
  parameter int RT_W        = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_ms,
  input  logic                  trigger,
  input  logic                  response,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic                  busy,
  output logic [RT_W-1:0]       react_ms,
  output logic                  react_valid,
  output logic                  false_start
);

  localparam int HOLD_MAX = MIN_HOLD_MS + (((1 << HOLD_BITS) - 1) << HOLD_SHIFT);
  localparam int STEP_W   = (STEP_MS > 1) ? $clog2(STEP_MS) : 1;
  localparam int HOLD_W   = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam int IDX_W    = $clog2(NUM_LIGHTS);

`ifdef F1_SEQ_BLINK_EN
  typedef enum logic [2:0] {IDLE, SEQ, HOLD, TIMING, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEQ, HOLD, TIMING} state_t;
`endif

  state_t                state, state_n;
  logic [15:0]           lfsr;
  logic                  trig_prev, resp_prev;
  logic [STEP_W-1:0]     step_cnt, step_cnt_n;
  logic [IDX_W-1:0]      idx, idx_n;
  logic [HOLD_W-1:0]     hold_cnt, hold_cnt_n, hold_last, hold_last_n, hold_len;
  logic [RT_W-1:0]       rt_cnt, rt_cnt_n, react_ms_n;
  logic [NUM_LIGHTS-1:0] lights_n;
  logic                  busy_n, react_valid_n, false_start_n;
  logic                  trig_rise, resp_rise, step_done, start, early;

  assign trig_rise = trigger & ~trig_prev;
  assign resp_rise = response & ~resp_prev;
  assign step_done = tick_ms && (step_cnt == STEP_W'(STEP_MS - 1));
  assign hold_len  = HOLD_W'(MIN_HOLD_MS) + (HOLD_W'(lfsr[HOLD_BITS-1:0]) << HOLD_SHIFT);
  assign early     = resp_rise && (state == SEQ || state == HOLD);
`ifdef F1_SEQ_BLINK_EN
  assign start     = trig_rise && (state == IDLE || state == FAULT);
`else
  assign start     = trig_rise && (state == IDLE);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lfsr        <= 16'hACE1;
      trig_prev   <= 1'b1;
      resp_prev   <= 1'b1;
      step_cnt    <= '0;
      idx         <= '0;
      hold_cnt    <= '0;
      hold_last   <= '0;
      rt_cnt      <= '0;
      lights      <= '0;
      busy        <= 1'b0;
      react_ms    <= '0;
      react_valid <= 1'b0;
      false_start <= 1'b0;
    end else begin
      state       <= state_n;
      lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3]};
      trig_prev   <= trigger;
      resp_prev   <= response;
      step_cnt    <= step_cnt_n;
      idx         <= idx_n;
      hold_cnt    <= hold_cnt_n;
      hold_last   <= hold_last_n;
      rt_cnt      <= rt_cnt_n;
      lights      <= lights_n;
      busy        <= busy_n;
      react_ms    <= react_ms_n;
      react_valid <= react_valid_n;
      false_start <= false_start_n;
    end
  end

  always_comb begin
    state_n       = state;
    step_cnt_n    = step_cnt;
    idx_n         = idx;
    hold_cnt_n    = hold_cnt;
    hold_last_n   = hold_last;
    rt_cnt_n      = rt_cnt;
    lights_n      = lights;
    busy_n        = busy;
    react_ms_n    = react_ms;
    react_valid_n = react_valid;
    false_start_n = false_start;
    if (start) begin
      lights_n      = NUM_LIGHTS'(1);
      busy_n        = 1'b1;
      react_valid_n = 1'b0;
      false_start_n = 1'b0;
      step_cnt_n    = '0;
      idx_n         = '0;
      state_n       = SEQ;
    end else if (early) begin
      false_start_n = 1'b1;
      busy_n        = 1'b0;
      react_valid_n = 1'b0;
`ifdef F1_SEQ_BLINK_EN
      lights_n      = '1;
      step_cnt_n    = '0;
      state_n       = FAULT;
`else
      lights_n      = '0;
      state_n       = IDLE;
`endif
    end else begin
      case (state)
        SEQ: begin
          if (tick_ms) step_cnt_n = step_cnt + STEP_W'(1);
          if (step_done) begin
            step_cnt_n = '0;
            if (idx < IDX_W'(NUM_LIGHTS - 1)) begin
              idx_n    = idx + IDX_W'(1);
              lights_n = {lights[NUM_LIGHTS-2:0], 1'b1};
            end else begin
              // A zero-length hold still lasts one tick.
              hold_last_n = (hold_len == '0) ? '0 : hold_len - HOLD_W'(1);
              hold_cnt_n  = '0;
              state_n     = HOLD;
            end
          end
        end
        HOLD: begin
          if (tick_ms) begin
            if (hold_cnt == hold_last) begin
              lights_n = '0;
              rt_cnt_n = '0;
              state_n  = TIMING;
            end else begin
              hold_cnt_n = hold_cnt + HOLD_W'(1);
            end
          end
        end
        TIMING: begin
          // Capture happens before any same-cycle increment.
          if (resp_rise) begin
            react_ms_n    = rt_cnt;
            react_valid_n = 1'b1;
            busy_n        = 1'b0;
            state_n       = IDLE;
          end else if (tick_ms && rt_cnt != '1) begin
            rt_cnt_n = rt_cnt + RT_W'(1);
          end
        end
`ifdef F1_SEQ_BLINK_EN
        FAULT: begin
          if (tick_ms) step_cnt_n = step_cnt + STEP_W'(1);
          if (step_done) begin
            step_cnt_n = '0;
            lights_n   = ~lights;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_f1_start_seq.sv
// tb/tb_f1_start_seq.sv - randomized directed bench for f1_start_seq against an event-time model
module tb_f1_start_seq;
  localparam int N      = 5;
  localparam int STEP   = 4;
  localparam int MINH   = 2;
  localparam int HB     = 2;
  localparam int HS     = 0;
  localparam int RTW    = 4;
  localparam int RT_MAX = (1 << RTW) - 1;
  localparam int ALL_ON = (1 << N) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_ms = 1'b0;
  logic trigger = 1'b0;
  logic response = 1'b0;
  logic [N-1:0]   lights;
  logic           busy;
  logic [RTW-1:0] react_ms;
  logic           react_valid;
  logic           false_start;

  int errors = 0;
  int checks = 0;
  int cyc_no = 0;
  int tick_mode = 0;
  int exp_react = 0;
  logic [15:0] m_lfsr = 16'hACE1;

  always #5 clk = ~clk;

  f1_start_seq #(
    .NUM_LIGHTS(N), .STEP_MS(STEP), .MIN_HOLD_MS(MINH),
    .HOLD_BITS(HB), .HOLD_SHIFT(HS), .RT_W(RTW)
  ) dut (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .trigger(trigger), .response(response),
    .lights(lights), .busy(busy), .react_ms(react_ms),
    .react_valid(react_valid), .false_start(false_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic next_tick();
    case (tick_mode)
      0:       return 1'b1;
      1:       return (cyc_no % 3 == 0);
      default: return logic'($urandom_range(0, 1));
    endcase
  endfunction

  function automatic int lamp_mask(input int ticks);
    int n;
    n = 1 + ticks / STEP;
    if (n > N) n = N;
    return (1 << n) - 1;
  endfunction

  task automatic cyc(input logic tk);
    tick_ms = tk;
    @(posedge clk);
    if (rst) m_lfsr = 16'hACE1;
    else     m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[14] ^ m_lfsr[12] ^ m_lfsr[3]};
    cyc_no++;
    #1;
  endtask

  task automatic start_run();
    trigger = 1'b0;
    cyc(next_tick());
    trigger = 1'b1;
    cyc(next_tick());
    chk("start_lights", lights, 1);
    chk("start_busy", busy, 1);
    chk("start_rv", react_valid, 0);
    chk("start_fs", false_start, 0);
    trigger = 1'b0;
  endtask

  // Walks the lamp sequence and hold until lights-out or stop_at ticks.
  task automatic run_lights(input int stop_at, input bit poke_trig, output int ticks);
    int tout, hl, guard;
    logic tk;
    bit done;
    tout = 1 << 30;
    ticks = 0;
    guard = 0;
    done = 0;
    while (!done && ticks < stop_at) begin
      tk = next_tick();
      if (poke_trig) trigger = logic'($urandom_range(0, 1));
      if (tk && ticks + 1 == N * STEP) begin
        hl = MINH + ((int'(m_lfsr) & ((1 << HB) - 1)) << HS);
        tout = N * STEP + ((hl == 0) ? 1 : hl);
      end
      cyc(tk);
      ticks += int'(tk);
      guard++;
      if (ticks >= tout) begin
        chk("lights_out", lights, 0);
        chk("busy_timing", busy, 1);
        done = 1;
      end else begin
        chk("lights_seq", lights, lamp_mask(ticks));
        chk("busy_seq", busy, 1);
      end
      if (guard > 3000) begin
        chk("seq_timeout", 1, 0);
        done = 1;
      end
    end
    trigger = 1'b0;
  endtask

  task automatic timing(input int wait_cyc);
    int rt;
    logic tk;
    rt = 0;
    for (int i = 0; i < wait_cyc; i++) begin
      tk = next_tick();
      cyc(tk);
      rt += int'(tk);
    end
    chk("timing_busy", busy, 1);
    response = 1'b1;
    cyc(next_tick());
    exp_react = (rt > RT_MAX) ? RT_MAX : rt;
    chk("react_ms", react_ms, exp_react);
    chk("react_valid", react_valid, 1);
    chk("react_busy", busy, 0);
    chk("react_lights", lights, 0);
    chk("react_fs", false_start, 0);
    response = 1'b0;
    cyc(next_tick());
    chk("react_hold", react_ms, exp_react);
  endtask

  task automatic fs_at(input int at_ticks);
    int t, ft, el;
    logic tk;
    start_run();
    run_lights(at_ticks, 1'b0, t);
    response = 1'b1;
    cyc(next_tick());
`ifdef F1_SEQ_BLINK_EN
    chk("fs_lights", lights, ALL_ON);
`else
    chk("fs_lights", lights, 0);
`endif
    chk("fs_flag", false_start, 1);
    chk("fs_busy", busy, 0);
    chk("fs_rv", react_valid, 0);
    chk("fs_react_kept", react_ms, exp_react);
    ft = 0;
    for (int i = 0; i < 12; i++) begin
      response = logic'($urandom_range(0, 1));
      tk = next_tick();
      cyc(tk);
      ft += int'(tk);
`ifdef F1_SEQ_BLINK_EN
      el = ((ft / STEP) % 2 == 0) ? ALL_ON : 0;
`else
      el = 0;
`endif
      chk("fs_idle_lights", lights, el);
      chk("fs_persist", false_start, 1);
    end
    response = 1'b0;
    cyc(next_tick());
  endtask

  initial begin
    int t;
    rst = 1'b1;
    trigger = 1'b1;
    cyc(1'b1);
    cyc(1'b1);
    chk("rst_lights", lights, 0);
    chk("rst_busy", busy, 0);
    chk("rst_react", react_ms, 0);
    chk("rst_rv", react_valid, 0);
    chk("rst_fs", false_start, 0);
    rst = 1'b0;
    repeat (3) cyc(1'b1);
    chk("held_trig_lights", lights, 0);
    chk("held_trig_busy", busy, 0);

    tick_mode = 0;
    start_run();
    run_lights(1000, 1'b0, t);
    timing(7);
    fs_at(2 * STEP);
    start_run();
    run_lights(1000, 1'b1, t);
    timing(20);

    tick_mode = 1;
    start_run();
    run_lights(1000, 1'b0, t);
    timing(5);

    // Asynchronous reset in the middle of the hold.
    start_run();
    run_lights(N * STEP + 1, 1'b0, t);
    #2 rst = 1'b1;
    #1;
    m_lfsr = 16'hACE1;
    exp_react = 0;
    chk("midhold_rst_lights", lights, 0);
    chk("midhold_rst_busy", busy, 0);
    chk("midhold_rst_react", react_ms, 0);
    chk("midhold_rst_rv", react_valid, 0);
    chk("midhold_rst_fs", false_start, 0);
    cyc(1'b1);
    rst = 1'b0;

    tick_mode = 2;
    for (int k = 0; k < 4; k++) begin
      start_run();
      run_lights(1000, (k % 2 == 1), t);
      timing($urandom_range(0, 25));
    end
    fs_at(N * STEP);
    start_run();
    run_lights(1000, 1'b0, t);
    timing(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
